cva6_cfg_dump_tx: RTL and testbench

//  Reads back the elaborated CVA6 configuration (config_pkg::cva6_cfg_t) and transmits it as a

---
 rtl/cva6_cfg_dump_tx.sv | 167 ++++++++++++++++
 tb/tb_cva6_cfg_dump_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_cfg_dump_tx.sv
// Streams the elaborated CVA6 configuration as a fixed sequence of 32-bit words over valid/ready.
// Optional trailing XOR checksum word when CVA6_CFG_DUMP_CHECKSUM_EN is defined.
package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        int unsigned VLEN;
        bit          RVA;
        bit          RVB;
        bit          RVC;
        bit          RVD;
        bit          RVF;
        bit          RVH;
        bit          RVV;
        bit          RVZCB;
        bit          RVZCMP;
        bit          RVZiCond;
        bit          CvxifEn;
        bit          MmuPresent;
        bit          RVS;
        bit          RVU;
        bit          DebugEn;
        bit          PerfCounterEn;
        bit          FpgaEn;
        bit          SuperscalarEn;
        int unsigned IcacheByteSize;
        int unsigned IcacheSetAssoc;
        int unsigned IcacheLineWidth;
        int unsigned DcacheByteSize;
        int unsigned DcacheSetAssoc;
        int unsigned DcacheLineWidth;
        int unsigned DCacheType;
        int unsigned AxiAddrWidth;
        int unsigned AxiDataWidth;
        int unsigned AxiIdWidth;
        int unsigned NrScoreboardEntries;
        int unsigned NrCommitPorts;
        int unsigned NrLoadBufEntries;
        int unsigned BTBEntries;
        int unsigned BHTEntries;
        int unsigned RASDepth;
        int unsigned NrPMPEntries;
        int unsigned DataTlbEntries;
        logic [63:0] HaltAddress;
        logic [63:0] ExceptionAddress;
        logic [63:0] DmBaseAddress;
        int unsigned InstrTlbEntries;
        int unsigned SharedTlbDepth;
        int unsigned MaxOutstandingStores;
    } cva6_cfg_t;
endpackage

module cva6_cfg_dump_tx #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = '0,
    parameter logic [31:0]           Magic   = 32'hCA6C_F600
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        abort_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o,
    output logic        busy_o
);

`ifdef CVA6_CFG_DUMP_CHECKSUM_EN
    localparam int unsigned NumWords = 17;
`else
    localparam int unsigned NumWords = 16;
`endif
    localparam logic [4:0] LastIdx = 5'(NumWords - 1);

    // Constant word map derived from the configuration at elaboration
    function automatic logic [15:0][31:0] build_words(config_pkg::cva6_cfg_t c);
        logic [15:0][31:0] w;
        w     = '0;
        w[0]  = Magic;
        w[1]  = {16'(c.VLEN), 16'(c.XLEN)};
        w[2]  = 32'({c.SuperscalarEn, c.FpgaEn, c.PerfCounterEn, c.DebugEn, c.RVU, c.RVS,
                     c.MmuPresent, c.CvxifEn, c.RVZiCond, c.RVZCMP, c.RVZCB, c.RVV, c.RVH,
                     c.RVF, c.RVD, c.RVC, c.RVB, c.RVA});
        w[3]  = 32'(c.IcacheByteSize);
        w[4]  = {16'(c.IcacheLineWidth), 16'(c.IcacheSetAssoc)};
        w[5]  = 32'(c.DcacheByteSize);
        w[6]  = {8'(c.DCacheType), 8'(c.DcacheLineWidth), 16'(c.DcacheSetAssoc)};
        w[7]  = {8'(c.AxiIdWidth), 8'(c.AxiDataWidth), 16'(c.AxiAddrWidth)};
        w[8]  = {8'(c.NrLoadBufEntries), 8'(c.NrCommitPorts), 16'(c.NrScoreboardEntries)};
        w[9]  = {8'(c.RASDepth), 12'(c.BHTEntries), 12'(c.BTBEntries)};
        w[10] = {16'(c.DataTlbEntries), 16'(c.NrPMPEntries)};
        w[11] = 32'(c.HaltAddress);
        w[12] = 32'(c.ExceptionAddress);
        w[13] = 32'(c.DmBaseAddress);
        w[14] = {16'(c.SharedTlbDepth), 16'(c.InstrTlbEntries)};
        w[15] = 32'(c.MaxOutstandingStores);
        return w;
    endfunction

    localparam logic [15:0][31:0] Words = build_words(CVA6Cfg);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e     state;
    logic [4:0] idx;
`ifdef CVA6_CFG_DUMP_CHECKSUM_EN
    logic [31:0] chk;
`endif

    // Dump sequencer; outputs are loaded with the word for the index being entered
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            idx     <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            busy_o  <= 1'b0;
`ifdef CVA6_CFG_DUMP_CHECKSUM_EN
            chk     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_i && !abort_i) begin
                        state   <= SEND;
                        idx     <= '0;
                        data_o  <= Words[0];
                        valid_o <= 1'b1;
                        last_o  <= 1'b0;
                        busy_o  <= 1'b1;
`ifdef CVA6_CFG_DUMP_CHECKSUM_EN
                        chk     <= '0;
`endif
                    end
                end
                SEND: begin
                    if (abort_i || (ready_i && last_o)) begin
                        state   <= IDLE;
                        idx     <= '0;
                        data_o  <= '0;
                        valid_o <= 1'b0;
                        last_o  <= 1'b0;
                        busy_o  <= 1'b0;
`ifdef CVA6_CFG_DUMP_CHECKSUM_EN
                        chk     <= '0;
`endif
                    end else if (ready_i) begin
                        idx    <= idx + 5'd1;
                        last_o <= ((idx + 5'd1) == LastIdx);
`ifdef CVA6_CFG_DUMP_CHECKSUM_EN
                        chk    <= chk ^ data_o;
                        // Word after idx 15 is the running XOR including the word now accepted
                        data_o <= (idx == 5'd15) ? (chk ^ data_o) : Words[4'(idx + 5'd1)];
`else
                        data_o <= Words[4'(idx + 5'd1)];
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cva6_cfg_dump_tx.sv
// Self-checking bench for cva6_cfg_dump_tx using cv64a6_imafdc_sv39-style configuration values.
`timescale 1ns/1ps
module tb_cva6_cfg_dump_tx;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        abort;
    logic        ready;
    logic [31:0] data;
    logic        valid;
    logic        last;
    logic        busy;

    function automatic config_pkg::cva6_cfg_t mk_cfg();
        config_pkg::cva6_cfg_t c;
        c = '0;
        c.XLEN = 64;               c.VLEN = 64;
        c.RVA = 1; c.RVB = 1; c.RVC = 1; c.RVD = 1; c.RVF = 1; c.RVH = 0; c.RVV = 0;
        c.RVZCB = 1; c.RVZCMP = 0; c.RVZiCond = 1; c.CvxifEn = 1; c.MmuPresent = 1;
        c.RVS = 1; c.RVU = 1; c.DebugEn = 1; c.PerfCounterEn = 1; c.FpgaEn = 0;
        c.SuperscalarEn = 0;
        c.IcacheByteSize = 16384;  c.IcacheSetAssoc = 4;  c.IcacheLineWidth = 128;
        c.DcacheByteSize = 32768;  c.DcacheSetAssoc = 8;  c.DcacheLineWidth = 128;
        c.DCacheType = 2;
        c.AxiAddrWidth = 64;       c.AxiDataWidth = 64;   c.AxiIdWidth = 4;
        c.NrScoreboardEntries = 8; c.NrCommitPorts = 2;   c.NrLoadBufEntries = 2;
        c.BTBEntries = 32;         c.BHTEntries = 128;    c.RASDepth = 2;
        c.NrPMPEntries = 8;        c.DataTlbEntries = 16;
        c.HaltAddress = 64'h800;   c.ExceptionAddress = 64'h808; c.DmBaseAddress = 64'h0;
        c.InstrTlbEntries = 16;    c.SharedTlbDepth = 64; c.MaxOutstandingStores = 7;
        return c;
    endfunction

    localparam config_pkg::cva6_cfg_t Cfg = mk_cfg();

`ifdef CVA6_CFG_DUMP_CHECKSUM_EN
    localparam int NW = 17;
`else
    localparam int NW = 16;
`endif

    cva6_cfg_dump_tx #(.CVA6Cfg(Cfg)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (req),
        .abort_i(abort),
        .data_o (data),
        .valid_o(valid),
        .ready_i(ready),
        .last_o (last),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic        last;
    } exp_t;

    typedef struct {
        logic        ready;
        logic [31:0] word;
        logic        last;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expw [17];
    exp_t        exp_q [$];
    vec_t        tbl [$];
    logic        mon_en   = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        for (int i = 0; i < NW; i++) exp_q.push_back('{word: expw[i], last: (i == NW - 1)});
    endtask

    task automatic drain(input string name, input int budget);
        for (int c = 0; c < budget && exp_q.size() > 0; c++) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: a word shown with valid&&ready at negedge is accepted at the next posedge
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (prev_hold) begin
                check("hold_data", data, prev_data);
                check("hold_last", 32'(last), 32'(prev_last));
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word actual=%h expected=none t=%0t", data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", data, e.word);
                    check("sb_last", 32'(last), 32'(e.last));
                end
            end
        end
        prev_hold = mon_en && valid && !ready;
        prev_data = data;
        prev_last = last;
    end

    initial begin
        expw[0]  = 32'hCA6C_F600;
        expw[1]  = 32'h0040_0040;
        expw[2]  = 32'h0000_FE9F;
        expw[3]  = 32'h0000_4000;
        expw[4]  = 32'h0080_0004;
        expw[5]  = 32'h0000_8000;
        expw[6]  = 32'h0280_0008;
        expw[7]  = 32'h0440_0040;
        expw[8]  = 32'h0202_0008;
        expw[9]  = 32'h0208_0020;
        expw[10] = 32'h0010_0008;
        expw[11] = 32'h0000_0800;
        expw[12] = 32'h0000_0808;
        expw[13] = 32'h0000_0000;
        expw[14] = 32'h0040_0010;
        expw[15] = 32'h0000_0007;
        expw[16] = '0;
        for (int i = 0; i < 16; i++) expw[16] = expw[16] ^ expw[i];

        // Table: each word once with ready=1, plus a stall record before word 3
        for (int i = 0; i < NW; i++) begin
            if (i == 3) tbl.push_back('{ready: 1'b0, word: expw[i], last: 1'b0});
            tbl.push_back('{ready: 1'b1, word: expw[i], last: (i == NW - 1)});
        end

        rst_n = 1'b0; req = 1'b0; abort = 1'b0; ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_valid", 32'(valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_data", data, 32'd0);
            check("idle_last", 32'(last), 32'd0);
            tick();
        end

        // Table-driven dump
        ready = 1'b1; req = 1'b1;
        tick();
        req = 1'b0;
        foreach (tbl[k]) begin
            ready = tbl[k].ready;
            @(negedge clk);
            check("tbl_valid", 32'(valid), 32'd1);
            check("tbl_data", data, tbl[k].word);
            check("tbl_last", 32'(last), 32'(tbl[k].last));
            tick();
        end
        @(negedge clk);
        check("after_busy", 32'(busy), 32'd0);
        check("after_valid", 32'(valid), 32'd0);
        tick();

        // Random backpressure
        mon_en = 1'b1;
        push_dump();
        ready = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 0; c < 2000 && exp_q.size() > 0; c++) begin
            ready = ($urandom_range(99) < 30);
            tick();
        end
        check("rand_drain", 32'(exp_q.size()), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        check("rand_busy", 32'(busy), 32'd0);
        tick();

        // Abort while word 5 is presented with ready high
        for (int i = 0; i < 6; i++) exp_q.push_back('{word: expw[i], last: 1'b0});
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_q", 32'(exp_q.size()), 32'd0);
        tick();
        push_dump();
        req = 1'b1;
        tick();
        req = 1'b0;
        drain("restart_drain", 200);

        // req held high through a dump: only one dump
        push_dump();
        req = 1'b1;
        tick();
        drain("held_drain", 200);
        req = 1'b0;
        @(negedge clk);
        check("held_busy", 32'(busy), 32'd0);
        repeat (4) tick();
        @(negedge clk);
        check("held_no_restart", 32'(valid), 32'd0);
        push_dump();
        req = 1'b1;
        tick();
        req = 1'b0;
        drain("second_drain", 200);

        // abort in IDLE wins over req
        tick();
        req = 1'b1; abort = 1'b1;
        tick();
        req = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_valid", 32'(valid), 32'd0);
        tick();

        // Reset mid-dump
        mon_en = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_last", 32'(last), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
